// File: rtl/dft_pkg.sv
// Shared TAP definitions: one-hot controller states, instruction opcodes
// and the boundary-scan control bundle.
package dft_pkg;

   typedef enum logic [15:0] {
      TLR    = 16'h0001,
      RTI    = 16'h0002,
      SEL_DR = 16'h0004,
      CAP_DR = 16'h0008,
      SH_DR  = 16'h0010,
      EX1_DR = 16'h0020,
      PAU_DR = 16'h0040,
      EX2_DR = 16'h0080,
      UPD_DR = 16'h0100,
      SEL_IR = 16'h0200,
      CAP_IR = 16'h0400,
      SH_IR  = 16'h0800,
      EX1_IR = 16'h1000,
      PAU_IR = 16'h2000,
      EX2_IR = 16'h4000,
      UPD_IR = 16'h8000
   } tap_state_e;

   typedef enum logic [1:0] {
      EXTEST = 2'b00,
      SAMPLE = 2'b01,
      SCAN   = 2'b10,
      BYPASS = 2'b11
   } tap_ins_e;

   localparam logic [1:0] IR_CAPTURE = 2'b01;

   typedef struct packed {
      logic clk_en;
      logic shift;
      logic update;
   } bsr_ctl_t;

   function automatic logic is_bsr_ins(input tap_ins_e ins);
      return (ins == EXTEST) || (ins == SAMPLE);
   endfunction

endpackage

// File: rtl/tap_fsm.sv
// 16-state TAP controller; state register is the only output, one-hot.
module tap_fsm
   import dft_pkg::*;
(
   input  logic       clock,
   input  logic       rst_l,
   input  logic       tms,
   output tap_state_e state
);

   always_ff @(posedge clock or negedge rst_l) begin
      if (!rst_l) begin
         state <= TLR;
      end else begin
         case (state)
            TLR:     state <= tms ? TLR    : RTI;
            RTI:     state <= tms ? SEL_DR : RTI;
            SEL_DR:  state <= tms ? SEL_IR : CAP_DR;
            CAP_DR:  state <= tms ? EX1_DR : SH_DR;
            SH_DR:   state <= tms ? EX1_DR : SH_DR;
            EX1_DR:  state <= tms ? UPD_DR : PAU_DR;
            PAU_DR:  state <= tms ? EX2_DR : PAU_DR;
            EX2_DR:  state <= tms ? UPD_DR : SH_DR;
            UPD_DR:  state <= tms ? SEL_DR : RTI;
            SEL_IR:  state <= tms ? TLR    : CAP_IR;
            CAP_IR:  state <= tms ? EX1_IR : SH_IR;
            SH_IR:   state <= tms ? EX1_IR : SH_IR;
            EX1_IR:  state <= tms ? UPD_IR : PAU_IR;
            PAU_IR:  state <= tms ? EX2_IR : PAU_IR;
            EX2_IR:  state <= tms ? UPD_IR : SH_IR;
            UPD_IR:  state <= tms ? SEL_DR : RTI;
            // a corrupted one-hot code recovers through the reset state
            default: state <= TLR;
         endcase
      end
   end

endmodule

// File: rtl/tap_ctrl.sv
// TAP controller top: instruction/bypass registers and output decode.
// Every output is a function of registered state, never of tms.
module tap_ctrl
   import dft_pkg::*;
(
   input  logic       clock,
   input  logic       rst_l,
   input  logic       tms,
   input  logic       tdi,
   output logic       tdo,
   input  logic       bsr_so,
   input  logic       scan_so,
   output logic       chain_si,
   output logic       bsr_shift,
   output logic       bsr_clk_en,
   output logic       bsr_update,
   output logic       bsr_sel,
   output logic       scan_sel,
   output logic [1:0] ir
);

   tap_state_e state;
   tap_ins_e   ir_q;
   tap_ins_e   ir_cur;
   logic [1:0] ir_sr;
   logic       byp;
   logic       bsr_ins;
   bsr_ctl_t   ctl;

   tap_fsm u_fsm (
      .clock (clock),
      .rst_l (rst_l),
      .tms   (tms),
      .state (state)
   );

   always_ff @(posedge clock or negedge rst_l) begin
      if (!rst_l) begin
         ir_q  <= BYPASS;
         ir_sr <= IR_CAPTURE;
         byp   <= 1'b0;
      end else begin
         case (state)
            TLR:     ir_q  <= BYPASS;
            CAP_IR:  ir_sr <= IR_CAPTURE;
            SH_IR:   ir_sr <= {tdi, ir_sr[1]};
            UPD_IR:  ir_q  <= tap_ins_e'(ir_sr);
            CAP_DR:  byp   <= 1'b0;
            SH_DR:   byp   <= tdi;
            default: ;
         endcase
      end
   end

   // BYPASS shows the moment TLR is entered, not one clock later
   assign ir_cur  = (state == TLR) ? BYPASS : ir_q;
   assign bsr_ins = is_bsr_ins(ir_cur);

   always_comb begin
      ctl        = '0;
      ctl.clk_en = bsr_ins && ((state == CAP_DR) || (state == SH_DR));
      ctl.shift  = bsr_ins && (state == SH_DR);
      ctl.update = bsr_ins && (state == UPD_DR);
   end

   always_comb begin
      tdo = 1'b0;
      if (state == SH_IR) begin
         tdo = ir_sr[0];
      end else if (state == SH_DR) begin
         case (ir_cur)
            EXTEST, SAMPLE: tdo = bsr_so;
            SCAN:           tdo = scan_so;
            default:        tdo = byp;
         endcase
      end
   end

   assign chain_si   = tdi;
   assign bsr_clk_en = ctl.clk_en;
   assign bsr_shift  = ctl.shift;
   assign bsr_update = ctl.update;
   assign bsr_sel    = (ir_cur == EXTEST);
   assign scan_sel   = (state == SH_DR) && (ir_cur == SCAN);
   assign ir         = ir_cur;

endmodule

// File: doc/tap_ctrl.md
TAP_CTRL -- requirements
Module: tap_ctrl

Interface
REQ-001 SHALL have these ports, clock and reset first:
- clock  in  1  single system/test clock; all state changes on rising edge
- rst_l  in  1  reset, asynchronous assert, active-low
- tms  in  1  test mode select, sampled on rising clock
- tdi  in  1  serial test data in
- tdo  out  1  serial test data out
- bsr_so  in  1  scan_out of last boundary-scan cell
- scan_so  in  1  serial out of internal scan chain (sc_dff/sc_dff_r)
- chain_si  out  1  serial in to boundary and internal chains; equals tdi
- bsr_shift  out  1  shift select for boundary cells
- bsr_clk_en  out  1  clock enable for boundary capture/shift flops
- bsr_update  out  1  update strobe for boundary hold flops
- bsr_sel  out  1  boundary output mux select; 1 = drive held value
- scan_sel  out  1  internal scan mux select; 1 = tdata path
- ir  out  2  current instruction
REQ-002 SHALL use one clock and an asynchronous active-low reset, named clock and rst_l.

Function
REQ-003 SHALL implement the standard 16-state TAP FSM (Test-Logic-Reset, Run-Test/Idle, Select/Capture/Shift/Exit1/Pause/Exit2/Update for DR and IR), advancing on tms each rising edge.
REQ-004 SHALL reach Test-Logic-Reset after 5 consecutive tms=1 cycles from any state.
REQ-005 SHALL decode all outputs from registered state only (no combinational tms paths), so bsr_update is glitch-free.
REQ-006 Instructions SHALL be: 00 EXTEST, 01 SAMPLE, 10 SCAN, 11 BYPASS.
REQ-007 IR shift register SHALL load 2'b01 in Capture-IR, shift right with tdi into MSB in Shift-IR; ir SHALL load from it in Update-IR only.
REQ-008 Bypass register (1 bit) SHALL clear in Capture-DR and load tdi in Shift-DR.
REQ-009 bsr_clk_en SHALL be 1 in Capture-DR and Shift-DR when ir is EXTEST or SAMPLE; bsr_shift SHALL be 1 only in Shift-DR for those instructions.
REQ-010 bsr_update SHALL be 1 for exactly one cycle per Update-DR visit when ir is EXTEST or SAMPLE.
REQ-011 bsr_sel SHALL equal 1 while ir==EXTEST, else 0, independent of FSM state.
REQ-012 scan_sel SHALL be 1 only in Shift-DR with ir==SCAN.
REQ-013 tdo SHALL be: Shift-IR -> IR shift LSB; Shift-DR -> bsr_so (EXTEST/SAMPLE), scan_so (SCAN), bypass bit (BYPASS); all other states -> 0.
REQ-014 In Test-Logic-Reset, ir SHALL be forced to BYPASS every cycle.
REQ-015 Pause states SHALL hold all shift registers unchanged and deassert all enables.

Reset
REQ-016 On rst_l=0: state=Test-Logic-Reset, ir=11, IR shift=01, bypass=0; tdo, bsr_shift, bsr_clk_en, bsr_update, bsr_sel, scan_sel all 0.
REQ-017 Reset asserted mid-shift SHALL abort immediately; no Update strobe SHALL occur for the aborted shift.

Structure
REQ-018 State encodings (one-hot, 16 bits) and instruction opcodes SHALL live in shared package/header dft_pkg.
REQ-019 FSM SHALL be sub-module tap_fsm (inputs clock, rst_l, tms; output one-hot state); tap_ctrl holds IR, bypass, and output decode.

Verification
REQ-020 From every state, tms=1 x5 -> state Test-Logic-Reset, ir=11.
REQ-021 Load IR=00 via Shift-IR with tdi=0,0 -> tdo shifts out 1,0; after Update-IR ir=00, bsr_sel=1.
REQ-022 ir=BYPASS, Shift-DR tdi pattern 1,0,1,1 -> tdo 0,1,0,1 (one-cycle delay).
REQ-023 ir=EXTEST, Capture-DR, 4 Shift-DR cycles, Exit1, Update-DR -> bsr_clk_en high 5 cycles, bsr_shift high 4, bsr_update high exactly 1.
REQ-024 ir=SCAN, Shift-DR -> scan_sel=1, tdo follows scan_so; Pause-DR -> scan_sel=0, tdo=0.
REQ-025 rst_l pulsed low during Shift-DR under EXTEST -> all outputs 0 within same cycle, no bsr_update pulse, ir=11.
